// File: rtl/wb_commit_pkg.sv
// Shared types for the writeback/commit stage.
// Slot bundle layout, GPR sizing and trace FSM encoding.
package wb_commit_pkg;

  localparam int GPR_W  = 32;
  localparam int ADDR_W = 5;

  typedef struct packed {
    logic              valid;
    logic [GPR_W-1:0]  pc;
    logic              wen;
    logic [ADDR_W-1:0] dest;
    logic [GPR_W-1:0]  result;
  } slot_t;

  localparam int SLOT_W = $bits(slot_t);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_C0   = 2'd1,
    ST_C1   = 2'd2
  } wb_state_e;

  function automatic logic slot_writes(
    input logic  ws_valid,
    input slot_t s
  );
    return ws_valid & s.valid & s.wen & (s.dest != '0);
  endfunction

endpackage

// File: rtl/wb_trace_fsm.sv
// Serialized commit sequencer: one slot per cycle, driving the trace port.
// Only instantiated when DEBUG_TRACE_EN is defined.
module wb_trace_fsm
  import wb_commit_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              accept_i,
  input  logic              ms0_valid_i,
  input  logic              ms1_valid_i,
  input  slot_t             slot0_i,
  input  slot_t             slot1_i,
  input  logic              wr0_i,
  input  logic              wr1_i,
  output logic              ready_go_o,
  output logic              cmt0_o,
  output logic              cmt1_o,
  output logic [GPR_W-1:0]  dbg_pc_o,
  output logic [3:0]        dbg_wen_o,
  output logic [ADDR_W-1:0] dbg_wnum_o,
  output logic [GPR_W-1:0]  dbg_wdata_o
);

  wb_state_e state_q, state_d;
  wb_state_e start_st;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Entry state for a bundle accepted this cycle.
  always_comb begin
    start_st = ST_IDLE;
    if (accept_i) begin
      if (ms0_valid_i)      start_st = ST_C0;
      else if (ms1_valid_i) start_st = ST_C1;
    end
  end

  always_comb begin
    state_d     = state_q;
    ready_go_o  = 1'b1;
    cmt0_o      = 1'b0;
    cmt1_o      = 1'b0;
    dbg_pc_o    = '0;
    dbg_wen_o   = '0;
    dbg_wnum_o  = '0;
    dbg_wdata_o = '0;
    unique case (state_q)
      ST_IDLE: begin
        state_d = start_st;
      end
      ST_C0: begin
        cmt0_o      = 1'b1;
        ready_go_o  = !slot1_i.valid;
        dbg_pc_o    = slot0_i.pc;
        dbg_wen_o   = {4{wr0_i}};
        dbg_wnum_o  = slot0_i.dest;
        dbg_wdata_o = slot0_i.result;
        state_d     = slot1_i.valid ? ST_C1 : start_st;
      end
      ST_C1: begin
        cmt1_o      = 1'b1;
        dbg_pc_o    = slot1_i.pc;
        dbg_wen_o   = {4{wr1_i}};
        dbg_wnum_o  = slot1_i.dest;
        dbg_wdata_o = slot1_i.result;
        state_d     = start_st;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/wb_commit.sv
// Dual-issue writeback stage; regfile commit, forwarding, trace port.
// Define DEBUG_TRACE_EN for serialized single-slot commit with trace.
module wb_commit
  import wb_commit_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              ms_to_ws_valid,
  output logic              ws_allowin,
  input  logic              ms0_valid,
  input  logic              ms1_valid,
  input  logic [GPR_W-1:0]  ms0_pc,
  input  logic [GPR_W-1:0]  ms1_pc,
  input  logic              ms0_wen,
  input  logic              ms1_wen,
  input  logic [ADDR_W-1:0] ms0_dest,
  input  logic [ADDR_W-1:0] ms1_dest,
  input  logic [GPR_W-1:0]  ms0_result,
  input  logic [GPR_W-1:0]  ms1_result,
  output logic              rf_we_01,
  output logic [ADDR_W-1:0] rf_waddr_01,
  output logic [GPR_W-1:0]  rf_wdata_01,
  output logic              rf_we_02,
  output logic [ADDR_W-1:0] rf_waddr_02,
  output logic [GPR_W-1:0]  rf_wdata_02,
  output logic              ws_fwd0_valid,
  output logic [ADDR_W-1:0] ws_fwd0_dest,
  output logic [GPR_W-1:0]  ws_fwd0_data,
  output logic              ws_fwd1_valid,
  output logic [ADDR_W-1:0] ws_fwd1_dest,
  output logic [GPR_W-1:0]  ws_fwd1_data,
  output logic [GPR_W-1:0]  debug_wb_pc,
  output logic [3:0]        debug_wb_rf_wen,
  output logic [ADDR_W-1:0] debug_wb_rf_wnum,
  output logic [GPR_W-1:0]  debug_wb_rf_wdata
);

  logic  ws_valid_q, ws_valid_d;
  logic  ws_ready_go;
  logic  accept;
  logic  wr0, wr1;
  slot_t slot0_q, slot0_d;
  slot_t slot1_q, slot1_d;

  assign ws_allowin = !ws_valid_q | ws_ready_go;
  assign accept     = ms_to_ws_valid & ws_allowin;

  always_comb begin
    ws_valid_d = ws_valid_q;
    if (accept)           ws_valid_d = 1'b1;
    else if (ws_ready_go) ws_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) ws_valid_q <= 1'b0;
    else         ws_valid_q <= ws_valid_d;
  end

  assign slot0_d = accept ? slot_t'{ms0_valid, ms0_pc, ms0_wen,
                                    ms0_dest, ms0_result}
                          : slot0_q;
  assign slot1_d = accept ? slot_t'{ms1_valid, ms1_pc, ms1_wen,
                                    ms1_dest, ms1_result}
                          : slot1_q;

  // Payload is qualified by ws_valid_q, so no reset needed.
  always_ff @(posedge clk) begin
    slot0_q <= slot0_d;
    slot1_q <= slot1_d;
  end

  assign wr0 = slot_writes(ws_valid_q, slot0_q);
  assign wr1 = slot_writes(ws_valid_q, slot1_q);

  assign rf_waddr_01  = slot0_q.dest;
  assign rf_wdata_01  = slot0_q.result;
  assign rf_waddr_02  = slot1_q.dest;
  assign rf_wdata_02  = slot1_q.result;
  assign ws_fwd0_dest = slot0_q.dest;
  assign ws_fwd0_data = slot0_q.result;
  assign ws_fwd1_dest = slot1_q.dest;
  assign ws_fwd1_data = slot1_q.result;

`ifdef DEBUG_TRACE_EN
  logic cmt0, cmt1;

  wb_trace_fsm u_trace (
    .clk_i       (clk),
    .rst_ni      (resetn),
    .accept_i    (accept),
    .ms0_valid_i (ms0_valid),
    .ms1_valid_i (ms1_valid),
    .slot0_i     (slot0_q),
    .slot1_i     (slot1_q),
    .wr0_i       (wr0),
    .wr1_i       (wr1),
    .ready_go_o  (ws_ready_go),
    .cmt0_o      (cmt0),
    .cmt1_o      (cmt1),
    .dbg_pc_o    (debug_wb_pc),
    .dbg_wen_o   (debug_wb_rf_wen),
    .dbg_wnum_o  (debug_wb_rf_wnum),
    .dbg_wdata_o (debug_wb_rf_wdata)
  );

  // Slot1 stays forwardable until its own C1 commit.
  assign rf_we_01      = wr0 & cmt0;
  assign rf_we_02      = wr1 & cmt1;
  assign ws_fwd0_valid = wr0 & cmt0;
  assign ws_fwd1_valid = wr1 & (cmt0 | cmt1);
`else
  logic unused_pc;

  assign unused_pc         = ^{slot0_q.pc, slot1_q.pc};
  assign ws_ready_go       = 1'b1;
  assign rf_we_01          = wr0;
  assign rf_we_02          = wr1;
  assign ws_fwd0_valid     = wr0;
  assign ws_fwd1_valid     = wr1;
  assign debug_wb_pc       = '0;
  assign debug_wb_rf_wen   = '0;
  assign debug_wb_rf_wnum  = '0;
  assign debug_wb_rf_wdata = '0;
`endif

endmodule

// File: tb/tb_wb_commit.sv
// Directed bench for wb_commit (default build or DEBUG_TRACE_EN).
// Regfile model applies port 01 then port 02 each edge.
module tb_wb_commit;

  logic        clk;
  logic        resetn;
  logic        ms_to_ws_valid;
  logic        ws_allowin;
  logic        ms0_valid, ms1_valid;
  logic [31:0] ms0_pc, ms1_pc;
  logic        ms0_wen, ms1_wen;
  logic [4:0]  ms0_dest, ms1_dest;
  logic [31:0] ms0_result, ms1_result;
  logic        rf_we_01, rf_we_02;
  logic [4:0]  rf_waddr_01, rf_waddr_02;
  logic [31:0] rf_wdata_01, rf_wdata_02;
  logic        ws_fwd0_valid, ws_fwd1_valid;
  logic [4:0]  ws_fwd0_dest, ws_fwd1_dest;
  logic [31:0] ws_fwd0_data, ws_fwd1_data;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;

  int n_err = 0;
  int n_chk = 0;

  logic [31:0] rf [32];
  logic        seen_b1 = 1'b0;

  wb_commit dut (
    .clk               (clk),
    .resetn            (resetn),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ws_allowin        (ws_allowin),
    .ms0_valid         (ms0_valid),
    .ms1_valid         (ms1_valid),
    .ms0_pc            (ms0_pc),
    .ms1_pc            (ms1_pc),
    .ms0_wen           (ms0_wen),
    .ms1_wen           (ms1_wen),
    .ms0_dest          (ms0_dest),
    .ms1_dest          (ms1_dest),
    .ms0_result        (ms0_result),
    .ms1_result        (ms1_result),
    .rf_we_01          (rf_we_01),
    .rf_waddr_01       (rf_waddr_01),
    .rf_wdata_01       (rf_wdata_01),
    .rf_we_02          (rf_we_02),
    .rf_waddr_02       (rf_waddr_02),
    .rf_wdata_02       (rf_wdata_02),
    .ws_fwd0_valid     (ws_fwd0_valid),
    .ws_fwd0_dest      (ws_fwd0_dest),
    .ws_fwd0_data      (ws_fwd0_data),
    .ws_fwd1_valid     (ws_fwd1_valid),
    .ws_fwd1_dest      (ws_fwd1_dest),
    .ws_fwd1_data      (ws_fwd1_data),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_wen   (debug_wb_rf_wen),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (rf_we_01) rf[rf_waddr_01] <= rf_wdata_01;
    if (rf_we_02) rf[rf_waddr_02] <= rf_wdata_02;
    if (rf_we_02 && rf_wdata_02 == 32'hB1) seen_b1 <= 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic load(
    input logic v0, input logic [31:0] pc0, input logic w0,
    input logic [4:0] d0, input logic [31:0] r0,
    input logic v1, input logic [31:0] pc1, input logic w1,
    input logic [4:0] d1, input logic [31:0] r1);
    ms_to_ws_valid = 1'b1;
    ms0_valid = v0; ms0_pc = pc0; ms0_wen = w0;
    ms0_dest = d0;  ms0_result = r0;
    ms1_valid = v1; ms1_pc = pc1; ms1_wen = w1;
    ms1_dest = d1;  ms1_result = r1;
  endtask

  task automatic idle();
    ms_to_ws_valid = 1'b0;
    ms0_valid = 1'b0;
    ms1_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn = 1'b0;
    idle();
    ms0_pc = '0; ms0_wen = 1'b0; ms0_dest = '0; ms0_result = '0;
    ms1_pc = '0; ms1_wen = 1'b0; ms1_dest = '0; ms1_result = '0;
    #3;
    chk("rst_allowin", ws_allowin, 1);
    chk("rst_we01", rf_we_01, 0);
    chk("rst_we02", rf_we_02, 0);
    chk("rst_fwd0", ws_fwd0_valid, 0);
    chk("rst_fwd1", ws_fwd1_valid, 0);
    chk("rst_dbgwen", debug_wb_rf_wen, 0);
    chk("rst_dbgpc", debug_wb_pc, 0);
    tick();
    tick();
    resetn = 1'b1;

`ifndef DEBUG_TRACE_EN
    // dual write, one cycle
    load(1, 32'h1000, 1, 3, 32'h11, 1, 32'h1004, 1, 4, 32'h22);
    tick();
    idle();
    chk("dual_we01", rf_we_01, 1);
    chk("dual_wa01", rf_waddr_01, 3);
    chk("dual_wd01", rf_wdata_01, 32'h11);
    chk("dual_we02", rf_we_02, 1);
    chk("dual_wa02", rf_waddr_02, 4);
    chk("dual_wd02", rf_wdata_02, 32'h22);
    chk("dual_fwd0", ws_fwd0_valid, 1);
    chk("dual_fwd1", ws_fwd1_valid, 1);
    chk("dual_allowin", ws_allowin, 1);
    chk("dual_dbgwen", debug_wb_rf_wen, 0);
    chk("dual_dbgpc", debug_wb_pc, 0);
    tick();
    chk("dual_done_we01", rf_we_01, 0);
    chk("dual_done_fwd0", ws_fwd0_valid, 0);
    chk("dual_done_fwd1", ws_fwd1_valid, 0);
    chk("rf3", rf[3], 32'h11);
    chk("rf4", rf[4], 32'h22);

    // same destination: slot1 wins
    load(1, 32'h1100, 1, 5, 32'hAA, 1, 32'h1104, 1, 5, 32'hBB);
    tick();
    idle();
    chk("same_we01", rf_we_01, 1);
    chk("same_we02", rf_we_02, 1);
    tick();
    chk("same_rf5", rf[5], 32'hBB);

    // dest 0 never writes
    load(1, 32'h1200, 1, 0, 32'h55, 0, 32'h1204, 1, 6, 32'h66);
    tick();
    idle();
    chk("d0_we01", rf_we_01, 0);
    chk("d0_fwd0", ws_fwd0_valid, 0);
    chk("d0_we02", rf_we_02, 0);
    chk("d0_dbgwen", debug_wb_rf_wen, 0);
    tick();

    // wen low
    load(1, 32'h1300, 0, 9, 32'h99, 0, 32'h0, 0, 0, 32'h0);
    tick();
    idle();
    chk("nowen_we01", rf_we_01, 0);
    chk("nowen_fwd0", ws_fwd0_valid, 0);
    tick();

    // empty bundle
    load(0, 32'h1400, 1, 7, 32'h77, 0, 32'h1404, 1, 8, 32'h88);
    tick();
    idle();
    chk("empty_we01", rf_we_01, 0);
    chk("empty_we02", rf_we_02, 0);
    chk("empty_allowin", ws_allowin, 1);
    tick();

    // back-to-back slot1-only
    load(0, 32'h0, 0, 0, 32'h0, 1, 32'h1500, 1, 6, 32'h61);
    tick();
    chk("b2b0_we02", rf_we_02, 1);
    chk("b2b0_wd02", rf_wdata_02, 32'h61);
    chk("b2b0_allowin", ws_allowin, 1);
    load(0, 32'h0, 0, 0, 32'h0, 1, 32'h1504, 1, 7, 32'h72);
    tick();
    idle();
    chk("b2b1_we02", rf_we_02, 1);
    chk("b2b1_wa02", rf_waddr_02, 7);
    chk("b2b1_allowin", ws_allowin, 1);
    tick();
    chk("b2b_rf6", rf[6], 32'h61);
    chk("b2b_rf7", rf[7], 32'h72);

    // async reset while a bundle is live
    load(1, 32'h1600, 1, 10, 32'hA0, 1, 32'h1604, 1, 11, 32'hB0);
    tick();
    idle();
    chk("rst2_pre_we01", rf_we_01, 1);
    resetn = 1'b0;
    #1;
    chk("rst2_we01", rf_we_01, 0);
    chk("rst2_we02", rf_we_02, 0);
    chk("rst2_fwd1", ws_fwd1_valid, 0);
    chk("rst2_allowin", ws_allowin, 1);
    tick();
    resetn = 1'b1;
    tick();
    chk("rst2_after_we02", rf_we_02, 0);
`else
    // serialized dual write; slot1 forwarding
    load(1, 32'h2000, 1, 3, 32'h11, 1, 32'h2004, 1, 7, 32'h33);
    tick();
    idle();
    chk("c0_we01", rf_we_01, 1);
    chk("c0_wa01", rf_waddr_01, 3);
    chk("c0_we02", rf_we_02, 0);
    chk("c0_dbgpc", debug_wb_pc, 32'h2000);
    chk("c0_dbgwen", debug_wb_rf_wen, 4'hF);
    chk("c0_dbgwnum", debug_wb_rf_wnum, 3);
    chk("c0_dbgwdata", debug_wb_rf_wdata, 32'h11);
    chk("c0_allowin", ws_allowin, 0);
    chk("c0_fwd0", ws_fwd0_valid, 1);
    chk("c0_fwd1", ws_fwd1_valid, 1);
    tick();
    chk("c1_we01", rf_we_01, 0);
    chk("c1_we02", rf_we_02, 1);
    chk("c1_wa02", rf_waddr_02, 7);
    chk("c1_dbgpc", debug_wb_pc, 32'h2004);
    chk("c1_dbgwdata", debug_wb_rf_wdata, 32'h33);
    chk("c1_allowin", ws_allowin, 1);
    chk("c1_fwd0", ws_fwd0_valid, 0);
    chk("c1_fwd1", ws_fwd1_valid, 1);
    tick();
    chk("idle_fwd1", ws_fwd1_valid, 0);
    chk("idle_dbgwen", debug_wb_rf_wen, 0);
    chk("idle_dbgpc", debug_wb_pc, 0);
    chk("rf3", rf[3], 32'h11);
    chk("rf7", rf[7], 32'h33);

    // same destination over two cycles
    load(1, 32'h2100, 1, 5, 32'hAA, 1, 32'h2104, 1, 5, 32'hBB);
    tick();
    idle();
    chk("same_c0_wdata", debug_wb_rf_wdata, 32'hAA);
    chk("same_c0_allowin", ws_allowin, 0);
    tick();
    chk("same_c1_wdata", debug_wb_rf_wdata, 32'hBB);
    tick();
    chk("same_rf5", rf[5], 32'hBB);

    // dest 0, slot0 only
    load(1, 32'h2200, 1, 0, 32'h55, 0, 32'h0, 0, 0, 32'h0);
    tick();
    idle();
    chk("d0_we01", rf_we_01, 0);
    chk("d0_fwd0", ws_fwd0_valid, 0);
    chk("d0_dbgwen", debug_wb_rf_wen, 0);
    chk("d0_dbgpc", debug_wb_pc, 32'h2200);
    chk("d0_allowin", ws_allowin, 1);
    tick();

    // empty bundle
    load(0, 32'h2280, 1, 6, 32'h66, 0, 32'h2284, 1, 6, 32'h67);
    tick();
    idle();
    chk("empty_we01", rf_we_01, 0);
    chk("empty_we02", rf_we_02, 0);
    chk("empty_dbgwen", debug_wb_rf_wen, 0);
    chk("empty_allowin", ws_allowin, 1);
    tick();

    // back-to-back slot1-only bundles
    load(0, 32'h0, 0, 0, 32'h0, 1, 32'h2300, 1, 8, 32'h81);
    tick();
    chk("b2b0_dbgpc", debug_wb_pc, 32'h2300);
    chk("b2b0_we02", rf_we_02, 1);
    chk("b2b0_allowin", ws_allowin, 1);
    load(0, 32'h0, 0, 0, 32'h0, 1, 32'h2304, 1, 9, 32'h92);
    tick();
    idle();
    chk("b2b1_dbgpc", debug_wb_pc, 32'h2304);
    chk("b2b1_dbgwnum", debug_wb_rf_wnum, 9);
    chk("b2b1_allowin", ws_allowin, 1);
    tick();
    chk("b2b_idle_dbgwen", debug_wb_rf_wen, 0);
    chk("b2b_rf8", rf[8], 32'h81);
    chk("b2b_rf9", rf[9], 32'h92);

    // reset in C0 with slot1 pending
    load(1, 32'h2400, 1, 10, 32'hA0, 1, 32'h2404, 1, 11, 32'hB1);
    tick();
    idle();
    chk("rst2_pre_we01", rf_we_01, 1);
    resetn = 1'b0;
    #1;
    chk("rst2_we01", rf_we_01, 0);
    chk("rst2_dbgpc", debug_wb_pc, 0);
    chk("rst2_dbgwen", debug_wb_rf_wen, 0);
    chk("rst2_fwd1", ws_fwd1_valid, 0);
    chk("rst2_allowin", ws_allowin, 1);
    tick();
    resetn = 1'b1;
    tick();
    chk("rst2_after_we02", rf_we_02, 0);
    chk("rst2_after_dbgwen", debug_wb_rf_wen, 0);
    chk("rst2_slot1_never", seen_b1, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
